// File: rtl/neuron_core_tm_if.sv
`default_nettype none
//============================================================================
// Module   : neuron_core_tm_if
// Brief    : Synaptic-event and spike handshake bundle for neuron_core_tm.
//            The master side is the crossbar/router pair, the slave side is
//            the neuron core.
// Revision : 1.0 - initial release
//============================================================================
interface neuron_core_tm_if #(
    parameter int W     = 8,
    parameter int IDX_W = 4
);
    // Weighted events from the synaptic crossbar
    logic             syn_valid;
    logic             syn_ready;
    logic [IDX_W-1:0] syn_idx;
    logic [W-1:0]     syn_weight;

    // Spike indices towards the spike router
    logic             spike_valid;
    logic             spike_ready;
    logic [IDX_W-1:0] spike_idx;

    modport master (
        output syn_valid, syn_idx, syn_weight, spike_ready,
        input  syn_ready, spike_valid, spike_idx
    );

    modport slave (
        input  syn_valid, syn_idx, syn_weight, spike_ready,
        output syn_ready, spike_valid, spike_idx
    );
endinterface
`default_nettype wire

// File: rtl/neuron_core_tm.sv
`default_nettype none
//============================================================================
// Module   : neuron_core_tm
// Brief    : Time-multiplexed core of N_NEURONS integrate-leak-fire neurons
//            sharing one evaluation datapath. Each tick sweeps all neurons
//            in ascending order; firing neurons emit their index over a
//            backpressured spike handshake. Synaptic events and config
//            writes are accepted only between sweeps.
// Revision : 1.0 - initial release
//============================================================================
module neuron_core_tm #(
    parameter int N_NEURONS = 16,
    parameter int W         = 8,
    parameter int REFRAC    = 2,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low

    // Per-neuron configuration write port
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [W-1:0]     cfg_pos_th,
    input  logic [W-1:0]     cfg_neg_th,
    input  logic             cfg_neg_en,
    input  logic [W-1:0]     cfg_v_reset,
    input  logic [W-1:0]     cfg_leak,
    input  logic [W-1:0]     cfg_rmask,

    // Synaptic event / spike handshakes
    neuron_core_tm_if.slave  bus,

    // Sweep control and status
    input  logic             tick,
    input  logic [W-1:0]     rand_in,
    output logic             busy,
    output logic             done,
    output logic             tick_overrun,

    // Membrane read port
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_potential
);

    // Refractory counter needs at least one bit even when the period is 0
    localparam int                  c_REF_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [c_REF_W-1:0]  c_REFRAC = c_REF_W'(REFRAC);
    localparam logic [IDX_W-1:0]    c_LAST   = IDX_W'(N_NEURONS - 1);
    localparam logic signed [W-1:0] c_VMAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] c_VMIN   = {1'b1, {(W-1){1'b0}}};

    // Sign-extend a W-bit value to the W+1-bit working width
    function automatic logic signed [W:0] sx(input logic [W-1:0] x);
        return {x[W-1], x};
    endfunction

    // Saturate a W+1-bit result into the signed W-bit range; any value that
    // does not fit has differing top two bits
    function automatic logic signed [W-1:0] sat(input logic signed [W:0] x);
        if (x[W] != x[W-1]) begin
            return x[W] ? c_VMIN : c_VMAX;
        end
        return x[W-1:0];
    endfunction

    //------------------------------------------------------------------------
    // Per-neuron state and configuration
    //------------------------------------------------------------------------
    logic signed [W-1:0] r_v       [N_NEURONS];
    logic [c_REF_W-1:0]  r_ref     [N_NEURONS];
    logic signed [W-1:0] r_pos_th  [N_NEURONS];
    logic [W-1:0]        r_neg_th  [N_NEURONS];
    logic                r_neg_en  [N_NEURONS];
    logic signed [W-1:0] r_v_reset [N_NEURONS];
    logic signed [W-1:0] r_leak    [N_NEURONS];
    logic [W-1:0]        r_rmask   [N_NEURONS];

    //------------------------------------------------------------------------
    // Sequencer and output registers
    //------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;
    logic                r_spk_valid;
    logic [IDX_W-1:0]    r_spk_idx;
    logic signed [W-1:0] r_rd;

    //------------------------------------------------------------------------
    // Shared evaluation datapath
    //------------------------------------------------------------------------
    logic                w_stall;
    logic                w_eval;
    logic                w_syn_fire;
    logic                w_fire;
    logic signed [W:0]   w_vp_sum;
    logic signed [W:0]   w_th_sum;
    logic signed [W:0]   w_floor;
    logic signed [W-1:0] w_vp;
    logic signed [W-1:0] w_th;
    logic signed [W-1:0] w_v_next   [N_NEURONS];
    logic [c_REF_W-1:0]  w_ref_next [N_NEURONS];

    // A held spike freezes the sweep so no spike can ever be overwritten
    assign w_stall    = r_spk_valid && !bus.spike_ready;
    assign w_eval     = (r_state == S_SWEEP) && !w_stall;
    assign w_syn_fire = bus.syn_valid && !r_busy && (int'(bus.syn_idx) < N_NEURONS);

    // Leaked potential, jittered threshold and negative floor of neuron r_ptr
    assign w_vp_sum = sx(r_v[r_ptr]) + sx(r_leak[r_ptr]);
    assign w_vp     = sat(w_vp_sum);
    assign w_th_sum = sx(r_pos_th[r_ptr]) + sx(rand_in & r_rmask[r_ptr]);
    assign w_th     = sat(w_th_sum);
    assign w_floor  = -$signed({1'b0, r_neg_th[r_ptr]});

    // Next membrane/refractory state: synaptic events between sweeps, one
    // neuron evaluation per unstalled sweep cycle (the two never coincide)
    always_comb begin
        w_v_next   = r_v;
        w_ref_next = r_ref;
        w_fire     = 1'b0;

        if (w_syn_fire && (r_ref[bus.syn_idx] == '0)) begin
            w_v_next[bus.syn_idx] = sat(sx(r_v[bus.syn_idx]) + sx(bus.syn_weight));
        end

        if (w_eval) begin
            if (r_ref[r_ptr] != '0) begin
                w_ref_next[r_ptr] = r_ref[r_ptr] - 1'b1;
                w_v_next[r_ptr]   = r_v_reset[r_ptr];
            end else if (w_vp >= w_th) begin
                w_fire            = 1'b1;
                w_v_next[r_ptr]   = r_v_reset[r_ptr];
                w_ref_next[r_ptr] = c_REFRAC;
            end else if (r_neg_en[r_ptr] && (sx(w_vp) < w_floor)) begin
                w_v_next[r_ptr]   = sat(w_floor);
            end else begin
                w_v_next[r_ptr]   = w_vp;
            end
        end
    end

    // Membrane and refractory state, plus the read port that shows the value
    // being committed at the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i]   <= '0;
                r_ref[i] <= '0;
            end
            r_rd <= '0;
        end else begin
            r_v   <= w_v_next;
            r_ref <= w_ref_next;
            r_rd  <= (int'(rd_idx) < N_NEURONS) ? w_v_next[rd_idx] : '0;
        end
    end

    // Configuration registers; writes during a sweep are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_pos_th[i]  <= c_VMAX;
                r_neg_th[i]  <= '0;
                r_neg_en[i]  <= 1'b0;
                r_v_reset[i] <= '0;
                r_leak[i]    <= '0;
                r_rmask[i]   <= '0;
            end
        end else if (cfg_we && !r_busy && (int'(cfg_idx) < N_NEURONS)) begin
            r_pos_th[cfg_idx]  <= cfg_pos_th;
            r_neg_th[cfg_idx]  <= cfg_neg_th;
            r_neg_en[cfg_idx]  <= cfg_neg_en;
            r_v_reset[cfg_idx] <= cfg_v_reset;
            r_leak[cfg_idx]    <= cfg_leak;
            r_rmask[cfg_idx]   <= cfg_rmask;
        end
    end

    // Sweep sequencer with registered busy/done/overrun and the spike register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_spk_valid <= 1'b0;
            r_spk_idx   <= '0;
        end else begin
            r_done <= 1'b0;

            // A reload on the handshake cycle keeps spike_valid high
            if (w_fire) begin
                r_spk_valid <= 1'b1;
                r_spk_idx   <= r_ptr;
            end else if (r_spk_valid && bus.spike_ready) begin
                r_spk_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (tick) begin
                        r_state <= S_SWEEP;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (tick) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_eval) begin
                        if (r_ptr == c_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign bus.syn_ready   = !r_busy;
    assign bus.spike_valid = r_spk_valid;
    assign bus.spike_idx   = r_spk_idx;
    assign busy            = r_busy;
    assign done            = r_done;
    assign tick_overrun    = r_overrun;
    assign rd_potential    = r_rd;

endmodule
`default_nettype wire

// File: doc/neuron_core_tm.md
# neuron_core_tm

Time-multiplexed, parametrised core of `N_NEURONS` integrate-leak-fire neurons sharing one evaluation datapath. It generalises the single `neuron_block` in three ways: per-neuron configuration, configurable membrane width and refractory period, and a backpressured spike output. It sits between the synaptic crossbar, which supplies weighted events, and the spike router, which consumes spike indices. One `tick` triggers one sweep over all neurons.

## Interface
- `N_NEURONS`, 16: neuron count, minimum 2.
- `W`, 8: signed membrane and weight width.
- `REFRAC`, 2: ticks a neuron skips after firing; 0 disables the refractory period.
- `IDX_W`, `$clog2(N_NEURONS)`: neuron index width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `cfg_we` in 1: per-neuron config write, accepted only when `busy`=0.
- `cfg_idx` in `IDX_W`: target neuron for the config write.
- `cfg_pos_th` in W: positive threshold, signed.
- `cfg_neg_th` in W: negative floor magnitude, unsigned.
- `cfg_neg_en` in 1: enables the negative floor.
- `cfg_v_reset` in W: post-spike potential, signed.
- `cfg_leak` in W: per-tick leak, signed, added to the potential.
- `cfg_rmask` in W: stochastic threshold mask.
- `syn_valid` in 1, `syn_ready` out 1: synaptic event handshake.
- `syn_idx` in `IDX_W`: target neuron for the synaptic event.
- `syn_weight` in W: signed synaptic weight.
- `tick` in 1: single-cycle sweep request.
- `rand_in` in W: random value, sampled during each neuron evaluation.
- `spike_valid` out 1, `spike_ready` in 1: spike handshake.
- `spike_idx` out `IDX_W`: index of the firing neuron.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse at sweep end.
- `tick_overrun` out 1: sticky flag, cleared only by reset.
- `rd_idx` in `IDX_W`, `rd_potential` out W: registered membrane read port.

## Operation
- **Arithmetic.** All sums are computed at W+1 bits, then saturated to [-2^(W-1), 2^(W-1)-1].
- **Per-neuron state.**
  - Potential V: W bits.
  - Refractory counter: `$clog2(REFRAC+1)` bits.
  - Config registers listed above.
- **Synaptic events.**
  - `syn_ready` = !`busy`.
  - On handshake: V[idx] = sat(V + weight).
  - If the target neuron's refractory counter is >0, the event is accepted and discarded.
- **FSM states: IDLE, SWEEP.**
  - IDLE → SWEEP on `tick`, with the index pointer set to 0.
  - `tick` while in SWEEP is ignored and sets `tick_overrun`.
- **Evaluation of neuron k in SWEEP.**
  - Refractory counter >0: decrement it; V = `v_reset`; no spike.
  - Otherwise: V' = sat(V + leak); eff_th = sat(pos_th + (`rand_in` & rmask)).
    - V' >= eff_th: spike; V = `v_reset`; counter = `REFRAC`.
    - Else, if `neg_en` and V' < -neg_th: V = -neg_th (clamp).
    - Else: V = V'.
- **Stall.** While `spike_valid`=1 and `spike_ready`=0, no neuron is evaluated and the pointer holds. This applies whether or not the next neuron would fire.
- **Spike register.** Loaded on a firing evaluation; cleared on handshake if no new spike is loaded in the same cycle. Spike order is ascending index, and no spike is ever dropped.
- **Sweep end.** After evaluating neuron N-1: go to IDLE and pulse `done`.
- **Config writes.** A config write while `busy`=1 is dropped. A write does not alter V or the refractory counter.

## Timing
- **Reset values.**
  - All V = 0; all refractory counters = 0.
  - `pos_th` = 2^(W-1)-1; `neg_en` = 0; `v_reset`, `leak`, `rmask`, `neg_th` = 0.
  - FSM in IDLE.
  - Outputs: `busy`, `done`, `spike_valid`, `spike_idx`, `tick_overrun`, `rd_potential` = 0; `syn_ready` = 1.
  - Reset mid-sweep aborts immediately; a pending spike is lost.
- **Sweep timing, no stalls.**
  - `tick` sampled at edge t → `busy`=1 after edge t.
  - Neuron k is evaluated in the cycle after edge t+k.
  - `busy` falls and `done` is high after edge t+N.
  - Sweep length is exactly N cycles.
- **Spike latency.** `spike_valid` rises one cycle after the firing evaluation. Each stalled cycle adds one cycle to the sweep.
- **Simultaneous events.**
  - A `syn_valid` and `tick` handshake in the same cycle: the synaptic event is applied first; the sweep sees the updated V.
  - Spike handshake and a new spike in the same cycle: the register reloads, and `spike_valid` stays 1.
- **Read port.** `rd_potential` = V[`rd_idx`] one cycle after `rd_idx` is sampled, and reflects writes committed at that edge.

## Test plan
All scenarios use W=8, N=4, REFRAC=2.

1. **Integration and fire.** n2: `pos_th`=0x40, `leak`=0. Send syn +0x30, then +0x20 to n2; then `tick` → one spike with `spike_idx`=2; V2=0x00; `done` 4 cycles after `tick`; no other spikes.
2. **Saturation and floor.**
   - V1=0x70, syn +0x20 → V1=0x7F.
   - n3: `neg_en`=1, `neg_th`=0x10; syn -0x30, then `tick` → V3=0xF0.
3. **Refractory period.** n0: `pos_th`=0x10, `leak`=+0x20; four ticks → spikes on ticks 1 and 4 only; V0=`v_reset` on ticks 2-3; syn events on ticks 2-3 are discarded.
4. **Backpressure.** All neurons have `leak`=0x7F; `spike_ready`=0 for 6 cycles after `tick`, then 1 → spikes delivered in order 0,1,2,3; none lost; `busy` extended by the stall cycles.
5. **Stochastic threshold.** n1: `pos_th`=0x40, `rmask`=0x0F, V1=0x48, `leak`=0.
   - `rand_in`=0x0F → no spike.
   - Re-set V1=0x48 via syn, `rand_in`=0x00 → spike with `spike_idx`=1.
6. **Reset and overrun.**
   - Extra `tick` mid-sweep → `tick_overrun`=1; sweep length unchanged.
   - `rst`=0 mid-sweep → `busy`, `spike_valid`, `tick_overrun` = 0 asynchronously; every V reads 0.
